// File: rtl/sa_job_scheduler.sv
// Round-robin scheduler sharing one SA_wrapper systolic array between N_REQ requesters.
// Define SA_SCHED_TIMEOUT_EN to abort CALC after TIMEOUT_CYC cycles with O_ERR.
//
// state | meaning
// IDLE  | arbitrate, latch grant when any request is present
// CLR   | sync-clear the array
// START | pulse array start
// CALC  | wait for array output valid (or timeout)
// DONE  | done pulse to the granted requester, then release grant

module sa_job_scheduler #(
    parameter int N_REQ       = 3,
    parameter int IDX_W       = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             I_CLK,
    input  logic             I_ASYN_RSTN,
    input  logic [N_REQ-1:0] I_REQ,
    output logic [N_REQ-1:0] O_GNT,
    output logic [IDX_W-1:0] O_GNT_IDX,
    output logic             O_SA_SYNC_RSTN,
    output logic             O_SA_START,
    input  logic             I_SA_OUT_VLD,
    output logic [N_REQ-1:0] O_DONE,
    output logic             O_BUSY,
    output logic             O_ERR,
    output logic [CNT_W-1:0] O_JOB_CNT
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("sa_job_scheduler: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_START,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic               arb_hit;
    logic [IDX_W-1:0]   arb_idx;
    logic [N_REQ-1:0]   arb_onehot;
    logic               timeout_hit;

    // First set request after the last winner, wrapping modulo N_REQ.
    always_comb begin
        int pos;
        pos        = 0;
        arb_hit    = 1'b0;
        arb_idx    = '0;
        arb_onehot = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = (int'(rr_ptr) + k) % N_REQ;
            if (!arb_hit && I_REQ[pos]) begin
                arb_hit         = 1'b1;
                arb_idx         = IDX_W'(pos);
                arb_onehot[pos] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arb_hit) state_nxt = S_CLR;
            S_CLR:   state_nxt = S_START;
            S_START: state_nxt = S_CALC;
            S_CALC:  if (I_SA_OUT_VLD || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Array controls are registered from the current state, so the clear reaches
    // the array one cycle after the grant and the start pulse two cycles after.
    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state          <= S_IDLE;
            rr_ptr         <= IDX_W'(N_REQ - 1);
            O_GNT          <= '0;
            O_GNT_IDX      <= '0;
            O_SA_SYNC_RSTN <= 1'b0;
            O_SA_START     <= 1'b0;
            O_DONE         <= '0;
            O_BUSY         <= 1'b0;
            O_JOB_CNT      <= '0;
        end else begin
            state          <= state_nxt;
            O_SA_SYNC_RSTN <= (state != S_CLR);
            O_SA_START     <= (state == S_START);
            O_BUSY         <= (state_nxt != S_IDLE);
            O_DONE         <= '0;
            if (state == S_IDLE && arb_hit) begin
                O_GNT     <= arb_onehot;
                O_GNT_IDX <= arb_idx;
                rr_ptr    <= arb_idx;
            end
            if (state == S_DONE) begin
                O_GNT <= '0;
            end
            if (state == S_CALC && state_nxt == S_DONE) begin
                O_DONE <= O_GNT;
                if (O_JOB_CNT != {CNT_W{1'b1}}) begin
                    O_JOB_CNT <= O_JOB_CNT + CNT_W'(1);
                end
            end
        end
    end

`ifdef SA_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;

    // Output valid on the last allowed cycle still counts as a good result.
    assign timeout_hit = (state == S_CALC) && !I_SA_OUT_VLD
                         && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            to_cnt <= '0;
            O_ERR  <= 1'b0;
        end else begin
            O_ERR <= timeout_hit;
            if (state != S_CALC) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign O_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_sa_job_scheduler.sv
// Scoreboard bench for sa_job_scheduler: expected jobs are queued by the stimulus and
// matched by a monitor against grants and done pulses; a small SA model answers starts.

module tb_sa_job_scheduler;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic [2:0]  req       = 3'b000;
    logic        vld_force = 1'b0;
    logic        sa_vld    = 1'b0;
    logic        vld;
    logic [2:0]  gnt;
    logic [1:0]  gnt_idx;
    logic        sync_rstn;
    logic        start;
    logic [2:0]  done;
    logic        busy;
    logic        err;
    logic [15:0] job_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int sa_lat   = 5;
    bit sa_never = 1'b0;
    bit sa_armed = 1'b0;
    int sa_cnt   = 0;
    bit clr_seen = 1'b0;

    typedef struct packed {
        logic [1:0] idx;
        logic       err;
    } job_t;

    job_t       exp_q[$];
    job_t       cur;
    bit         cur_vld  = 1'b0;
    int         exp_cnt  = 0;
    logic [2:0] gnt_prev = 3'b000;

    assign vld = sa_vld | vld_force;

    sa_job_scheduler #(
        .N_REQ       (3),
        .IDX_W       (2),
        .TIMEOUT_CYC (16),
        .CNT_W       (16)
    ) dut (
        .I_CLK          (clk),
        .I_ASYN_RSTN    (rst_n),
        .I_REQ          (req),
        .O_GNT          (gnt),
        .O_GNT_IDX      (gnt_idx),
        .O_SA_SYNC_RSTN (sync_rstn),
        .O_SA_START     (start),
        .I_SA_OUT_VLD   (vld),
        .O_DONE         (done),
        .O_BUSY         (busy),
        .O_ERR          (err),
        .O_JOB_CNT      (job_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_job(input int idx, input bit e);
        job_t j;
        j.idx = 2'(idx);
        j.err = e;
        exp_q.push_back(j);
    endtask

    // SA model: output valid sa_lat cycles after a start; every start needs a prior clear.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_vld   = 1'b0;
            sa_armed = 1'b0;
            sa_cnt   = 0;
            clr_seen = 1'b0;
        end else begin
            sa_vld = 1'b0;
            if (!sync_rstn) clr_seen = 1'b1;
            if (start) begin
                chk("sync_before_start", int'(clr_seen), 1);
                clr_seen = 1'b0;
                sa_armed = !sa_never;
                sa_cnt   = sa_lat;
            end else if (sa_armed) begin
                if (sa_cnt <= 1) begin
                    sa_vld   = 1'b1;
                    sa_armed = 1'b0;
                end else begin
                    sa_cnt--;
                end
            end
        end
    end

    // Monitor: pops an expected job on each new grant and checks it at the done pulse.
    always @(negedge clk) begin
        logic [2:0] one;
        one = 3'b001;
        if (!rst_n) begin
            exp_q.delete();
            cur_vld  = 1'b0;
            exp_cnt  = 0;
            gnt_prev = 3'b000;
        end else begin
            if (gnt != 3'b000) chk("gnt_onehot", int'($onehot(gnt)), 1);
            if (gnt != 3'b000 && gnt_prev == 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", int'(gnt), 0);
                end else begin
                    cur     = exp_q.pop_front();
                    cur_vld = 1'b1;
                    chk("gnt_idx", int'(gnt_idx), int'(cur.idx));
                    chk("gnt_vec", int'(gnt), int'(one << cur.idx));
                end
            end
            if (done != 3'b000) begin
                if (!cur_vld) begin
                    chk("unexpected_done", int'(done), 0);
                end else begin
                    exp_cnt++;
                    chk("done_vec", int'(done), int'(one << cur.idx));
                    chk("gnt_during_done", int'(gnt), int'(one << cur.idx));
                    chk("done_err", int'(err), int'(cur.err));
                    chk("job_cnt", int'(job_cnt), exp_cnt);
                    cur_vld = 1'b0;
                end
            end else if (err) begin
                chk("err_without_done", int'(err), 0);
            end
            gnt_prev = gnt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (done != 3'b000) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_gnt(output int gc);
        gc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (gnt != 3'b000) begin
                gc = cyc;
                break;
            end
        end
        if (gc < 0) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_start();
        int hit;
        hit = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (start) begin
                hit = 1;
                break;
            end
        end
        if (hit == 0) chk("start_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_chk - n_fail, n_chk);
        $fatal(1);
    end

    initial begin
        int c0;
        int dc;
        int gc;

        #2 rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_gnt_idx", int'(gnt_idx), 0);
        chk("rst_sync_rstn", int'(sync_rstn), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_job_cnt", int'(job_cnt), 0);
        step();
        rst_n = 1'b1;
        step();

        // Test 1: single request, latency of grant/clear/start/done
        sa_lat = 40;
        req    = 3'b010;
        push_job(1, 1'b0);
        c0 = cyc;
        @(negedge clk);
        chk("t1_gnt_t0", int'(gnt), 0);
        @(negedge clk);
        chk("t1_gnt_t1", int'(gnt), 2);
        chk("t1_sync_t1", int'(sync_rstn), 1);
        chk("t1_busy_t1", int'(busy), 1);
        @(negedge clk);
        chk("t1_sync_t2", int'(sync_rstn), 0);
        chk("t1_start_t2", int'(start), 0);
        @(negedge clk);
        chk("t1_start_t3", int'(start), 1);
        chk("t1_sync_t3", int'(sync_rstn), 1);
        @(negedge clk);
        chk("t1_start_t4", int'(start), 0);
        wait_done(dc);
        chk("t1_done_lat", dc - c0, 44);
        step();
        req = 3'b000;
        @(negedge clk);
        chk("t1_idle_busy", int'(busy), 0);

        // Test 2: all requesting from reset -> 0,1,2,0,1,2 with 2-cycle gap
        pulse_reset();
        sa_lat = 5;
        req    = 3'b111;
        for (int j = 0; j < 6; j++) push_job(j % 3, 1'b0);
        for (int j = 0; j < 6; j++) begin
            wait_done(dc);
            step();
            if (j == 5) begin
                req = 3'b000;
            end else begin
                wait_gnt(gc);
                chk("t2_gap", gc - dc, 2);
            end
        end

        // Test 3: requester 0 drops mid-job, job still completes, then requester 1
        sa_lat = 20;
        req    = 3'b011;
        push_job(0, 1'b0);
        push_job(1, 1'b0);
        wait_start();
        step();
        step();
        req[0] = 1'b0;
        wait_done(dc);
        step();
        wait_gnt(gc);
        chk("t3_gap", gc - dc, 2);
        wait_done(dc);
        step();
        req = 3'b000;

        // Test 6: valid forced outside CALC is ignored
        vld_force = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t6_idle_busy", int'(busy), 0);
        end
        step();
        sa_lat = 6;
        req    = 3'b100;
        push_job(2, 1'b0);
        c0 = cyc;
        step();
        step();
        step();
        vld_force = 1'b0;
        wait_done(dc);
        chk("t6_done_lat", dc - c0, 10);
        step();
        req = 3'b000;

        // Test 4: async reset during CALC, then re-grant from IDLE
        sa_lat = 50;
        req    = 3'b100;
        push_job(2, 1'b0);
        wait_start();
        step();
        step();
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("t4_gnt", int'(gnt), 0);
        chk("t4_gnt_idx", int'(gnt_idx), 0);
        chk("t4_sync_rstn", int'(sync_rstn), 0);
        chk("t4_start", int'(start), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_job_cnt", int'(job_cnt), 0);
        @(negedge clk);
        step();
        step();
        rst_n  = 1'b1;
        sa_lat = 4;
        push_job(2, 1'b0);
        c0 = cyc;
        wait_gnt(gc);
        chk("t4_regrant_lat", gc - c0, 1);
        wait_done(dc);
        step();
        req = 3'b000;

        // Test 5: SA never answers
        sa_never = 1'b1;
        step();
`ifdef SA_SCHED_TIMEOUT_EN
        req = 3'b001;
        push_job(0, 1'b1);
        c0 = cyc;
        wait_done(dc);
        chk("t5_timeout_lat", dc - c0, 19);
        step();
        req      = 3'b000;
        sa_never = 1'b0;
        sa_lat   = 15;
        step();
        req = 3'b010;
        push_job(1, 1'b0);
        c0 = cyc;
        wait_done(dc);
        chk("t5_vld_wins_lat", dc - c0, 19);
        step();
        req = 3'b000;
`else
        req = 3'b001;
        push_job(0, 1'b0);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("t5_still_busy", int'(busy), 1);
        chk("t5_no_done", int'(done), 0);
        req      = 3'b000;
        sa_never = 1'b0;
        pulse_reset();
`endif

        step();
        @(negedge clk);
        chk("sb_drained", exp_q.size() + int'(cur_vld), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
